// File: rtl/pmm_host_interface_if.sv
// Bus bundle between the core's data-memory port / engines and the pattern-matching host front end.
interface pmm_host_interface_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64
);
  logic [31:0]              daddr;
  logic [31:0]              dwdata;
  logic [3:0]               dwe;
  logic [31:0]              drdata;
  logic [NUM_CH*DATA_W-1:0] pmm_data;
  logic [NUM_CH*16-1:0]     pmm_control;
  logic [NUM_CH-1:0]        pmm_start;
  logic [NUM_CH-1:0]        pmm_done;
  logic                     irq;

  modport master (
    output daddr, dwdata, dwe, pmm_done,
    input  drdata, pmm_data, pmm_control, pmm_start, irq
  );

  modport slave (
    input  daddr, dwdata, dwe, pmm_done,
    output drdata, pmm_data, pmm_control, pmm_start, irq
  );
endinterface

// File: rtl/pmm_host_interface.sv
// Memory-mapped front end: stages a pattern, commits it to one of NUM_CH engines,
// tracks busy/done per channel, and raises a maskable interrupt.
module pmm_host_interface #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pmm_host_interface_if.slave   bus
);
  localparam int unsigned DW = DATA_W / 32;
  localparam int unsigned AW = 6;
  localparam logic [AW-1:0] A_CMD    = AW'(DW);
  localparam logic [AW-1:0] A_STATUS = AW'(DW + 1);
  localparam logic [AW-1:0] A_DONE   = AW'(DW + 2);
  localparam logic [AW-1:0] A_IRQEN  = AW'(DW + 3);

  logic [DATA_W-1:0]        stage_q;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH*16-1:0]     ctrl_q;
  logic [NUM_CH-1:0]        start_q;
  logic [NUM_CH-1:0]        busy_q;
  logic [NUM_CH-1:0]        done_q;
  logic [NUM_CH-1:0]        irq_en_q;
  logic                     cmd_err_q;
  logic                     irq_q;
  logic [31:0]              rdata_q;

  logic [AW-1:0]     widx_c;
  logic              wr_c;
  logic [31:0]       bmask_c;
  logic              cmd_wr_c;
  logic [15:0]       cmd_ch_c;
  logic              launch_mode_c;
  logic [NUM_CH-1:0] accept_c;
  logic [NUM_CH-1:0] launch_c;
  logic [NUM_CH-1:0] done_set_c;
  logic [NUM_CH-1:0] done_clr_c;
  logic              err_clr_c;
  logic [31:0]       rd_c;
  logic              unused_addr_c;

  assign widx_c        = bus.daddr[7:2];
  assign unused_addr_c = ^{bus.daddr[31:8], bus.daddr[1:0]};
  assign wr_c          = |bus.dwe;
  assign bmask_c       = {{8{bus.dwe[3]}}, {8{bus.dwe[2]}}, {8{bus.dwe[1]}}, {8{bus.dwe[0]}}};
  assign cmd_wr_c      = (bus.dwe == 4'hF) && (widx_c == A_CMD);
  assign cmd_ch_c      = bus.dwdata[15:0];
  assign launch_mode_c = |bus.dwdata[31:30];
  assign launch_c      = accept_c & {NUM_CH{launch_mode_c}};
  assign done_set_c    = bus.pmm_done & busy_q;
  assign done_clr_c    = (wr_c && (widx_c == A_DONE)) ? NUM_CH'(bus.dwdata & bmask_c) : '0;
  assign err_clr_c     = wr_c && (widx_c == A_STATUS) && bus.dwe[3] && bus.dwdata[31];

  // A commit lands only on an in-range channel that was idle before this edge
  always_comb begin
    accept_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      accept_c[c] = cmd_wr_c && (cmd_ch_c == 16'(c)) && !busy_q[c];
    end
  end

  // Read mux over pre-write state
  always_comb begin
    rd_c = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (widx_c == AW'(i)) rd_c = stage_q[32*i +: 32];
    end
    if (widx_c == A_STATUS) rd_c = {cmd_err_q, 31'(busy_q)};
    if (widx_c == A_DONE)   rd_c = 32'(done_q);
    if (widx_c == A_IRQEN)  rd_c = 32'(irq_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      start_q   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      irq_en_q  <= '0;
      cmd_err_q <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DW; i++) begin
        if (wr_c && (widx_c == AW'(i))) begin
          stage_q[32*i +: 32] <= (stage_q[32*i +: 32] & ~bmask_c) | (bus.dwdata & bmask_c);
        end
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (accept_c[c]) begin
          data_q[c*DATA_W +: DATA_W] <= stage_q;
          ctrl_q[c*16 +: 16]         <= bus.dwdata[31:16];
        end
      end
      start_q <= launch_c;
      busy_q  <= (busy_q & ~done_set_c) | launch_c;
      // Hardware completion beats a same-cycle software clear
      done_q  <= done_set_c | (done_q & ~done_clr_c & ~launch_c);
      if (cmd_wr_c && (accept_c == '0)) cmd_err_q <= 1'b1;
      else if (err_clr_c)               cmd_err_q <= 1'b0;
      if (wr_c && (widx_c == A_IRQEN)) begin
        irq_en_q <= (irq_en_q & ~NUM_CH'(bmask_c)) | NUM_CH'(bus.dwdata & bmask_c);
      end
      irq_q   <= |(done_q & irq_en_q);
      rdata_q <= rd_c;
    end
  end

  assign bus.drdata      = rdata_q;
  assign bus.pmm_data    = data_q;
  assign bus.pmm_control = ctrl_q;
  assign bus.pmm_start   = start_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_pmm_host_interface.sv
// Directed bench for pmm_host_interface (NUM_CH=4, DATA_W=64: CMD=0x08, STATUS=0x0C, DONE=0x10, IRQ_EN=0x14).
module tb_pmm_host_interface;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 64;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pmm_host_interface_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus();

  pmm_host_interface #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.daddr  = addr;
    bus.dwdata = data;
    bus.dwe    = be;
    @(negedge clk);
    bus.dwe    = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.daddr = addr;
    bus.dwe   = 4'h0;
    @(negedge clk);
    data = bus.drdata;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    rd(addr, v);
    check(tag, 64'(v), 64'(exp));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.daddr   = '0;
    bus.dwdata  = '0;
    bus.dwe     = '0;
    bus.pmm_done = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of every map word plus two unmapped words
    for (int i = 0; i < 8; i++) rd_check($sformatf("reset_rd%0d", i), 32'(i * 4), 32'h0);
    check("reset_irq", 64'(bus.irq), 64'h0);
    check("reset_start", 64'(bus.pmm_start), 64'h0);

    // Stage and commit to channel 2
    wr(32'h00, 32'hDEADBEEF, 4'hF);
    wr(32'h04, 32'h01234567, 4'hF);
    wr(32'h08, 32'h4ABC0002, 4'hF);
    check("commit_start", 64'(bus.pmm_start), 64'h4);
    check("commit_data2", bus.pmm_data[2*DATA_W +: DATA_W], 64'h01234567DEADBEEF);
    check("commit_ctrl2", 64'(bus.pmm_control[2*16 +: 16]), 64'h4ABC);
    @(negedge clk);
    check("start_one_cycle", 64'(bus.pmm_start), 64'h0);
    rd_check("status_busy2", 32'h0C, 32'h4);
    rd_check("stage_kept", 32'h00, 32'hDEADBEEF);

    // Rejections: busy channel, then out-of-range channel
    wr(32'h00, 32'h11111111, 4'hF);
    wr(32'h08, 32'h40000002, 4'hF);
    check("busy_no_start", 64'(bus.pmm_start), 64'h0);
    rd_check("status_err_busy", 32'h0C, 32'h80000004);
    check("busy_data_kept", bus.pmm_data[2*DATA_W +: DATA_W], 64'h01234567DEADBEEF);
    wr(32'h08, 32'h40000007, 4'hF);
    check("range_no_start", 64'(bus.pmm_start), 64'h0);
    rd_check("status_err_range", 32'h0C, 32'h80000004);
    wr(32'h0C, 32'h80000000, 4'hF);
    rd_check("status_err_clr", 32'h0C, 32'h4);
    wr(32'h00, 32'hDEADBEEF, 4'hF);

    // Done pulse on channel 2 with IRQ enabled
    wr(32'h14, 32'h4, 4'hF);
    rd_check("irq_en_rd", 32'h14, 32'h4);
    @(negedge clk) bus.pmm_done = 4'h4;
    @(negedge clk) bus.pmm_done = 4'h0;
    check("irq_not_yet", 64'(bus.irq), 64'h0);
    @(negedge clk);
    check("irq_rise", 64'(bus.irq), 64'h1);
    rd_check("status_idle", 32'h0C, 32'h0);
    rd_check("done_set", 32'h10, 32'h4);
    // Done on an idle channel is ignored
    @(negedge clk) bus.pmm_done = 4'h2;
    @(negedge clk) bus.pmm_done = 4'h0;
    rd_check("done_idle_ignored", 32'h10, 32'h4);
    wr(32'h10, 32'h4, 4'hF);
    @(negedge clk);
    check("irq_clr", 64'(bus.irq), 64'h0);
    rd_check("done_w1c", 32'h10, 32'h0);

    // W1C racing a fresh done: the set wins
    wr(32'h08, 32'h40000002, 4'hF);
    check("relaunch_start", 64'(bus.pmm_start), 64'h4);
    @(negedge clk);
    bus.daddr = 32'h10; bus.dwdata = 32'h4; bus.dwe = 4'hF; bus.pmm_done = 4'h4;
    @(negedge clk);
    bus.dwe = 4'h0; bus.pmm_done = 4'h0;
    rd_check("done_set_wins", 32'h10, 32'h4);

    // Commit to busy channel in the same cycle as its done: rejected, done still lands
    wr(32'h08, 32'h40000002, 4'hF);
    @(negedge clk);
    bus.daddr = 32'h08; bus.dwdata = 32'h40000002; bus.dwe = 4'hF; bus.pmm_done = 4'h4;
    @(negedge clk);
    bus.dwe = 4'h0; bus.pmm_done = 4'h0;
    check("race_no_start", 64'(bus.pmm_start), 64'h0);
    rd_check("race_status", 32'h0C, 32'h80000000);
    rd_check("race_done", 32'h10, 32'h4);
    wr(32'h0C, 32'h80000000, 4'hF);

    // Byte-enable granularity and partial CMD write
    wr(32'h00, 32'hFFFFFFFF, 4'b0011);
    rd_check("partial_stage", 32'h00, 32'hDEADFFFF);
    wr(32'h08, 32'h40000001, 4'b0111);
    check("partial_cmd_start", 64'(bus.pmm_start), 64'h0);
    check("partial_cmd_ctrl1", 64'(bus.pmm_control[1*16 +: 16]), 64'h0);
    rd_check("partial_cmd_status", 32'h0C, 32'h0);

    // Configuration-only commit
    wr(32'h08, 32'h00110001, 4'hF);
    check("mode0_start", 64'(bus.pmm_start), 64'h0);
    check("mode0_ctrl1", 64'(bus.pmm_control[1*16 +: 16]), 64'h0011);
    check("mode0_data1", bus.pmm_data[1*DATA_W +: DATA_W], 64'h01234567DEADFFFF);
    rd_check("mode0_status", 32'h0C, 32'h0);

    // Back-to-back commits to channels 0 and 3
    @(negedge clk);
    bus.daddr = 32'h08; bus.dwdata = 32'h80000000; bus.dwe = 4'hF;
    @(negedge clk);
    check("b2b_start0", 64'(bus.pmm_start), 64'h1);
    bus.dwdata = 32'hC0000003;
    @(negedge clk);
    bus.dwe = 4'h0;
    check("b2b_start3", 64'(bus.pmm_start), 64'h8);
    rd_check("b2b_status", 32'h0C, 32'h9);

    // Asynchronous reset with a start pulse in flight
    @(negedge clk);
    bus.daddr = 32'h08; bus.dwdata = 32'h40000001; bus.dwe = 4'hF;
    @(posedge clk);
    #1;
    check("inflight_start", 64'(bus.pmm_start), 64'h2);
    rst_n = 1'b0;
    #1;
    check("arst_start", 64'(bus.pmm_start), 64'h0);
    check("arst_data", 64'(|bus.pmm_data), 64'h0);
    check("arst_ctrl", 64'(|bus.pmm_control), 64'h0);
    check("arst_irq", 64'(bus.irq), 64'h0);
    bus.dwe = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rd_check($sformatf("post_arst_rd%0d", i), 32'(i * 4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pmm_host_interface.md
# pmm_host_interface

Parametrised memory-mapped front end for the pattern-matching peripheral. It sits between the core's data-memory bus and NUM_CH pattern-matching engines. It stages a DATA_W-bit pattern word by word, commits pattern plus 16-bit control to one selected engine with a start pulse, and tracks per-channel busy/done state. It provides sticky error reporting, write-1-to-clear done bits, a maskable interrupt and registered readback.

## Interface
Parameters:
- NUM_CH, 4: number of engine channels; legal range 1..16.
- DATA_W, 64: pattern width; a multiple of 32, legal range 32..256. DW = DATA_W/32 staging words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- daddr  in  32  byte address; word index a = daddr[7:2]; daddr[1:0] ignored.
- dwdata  in  32  write data.
- dwe  in  4  per-byte write enables; a write occurs when dwe != 0.
- drdata  out  32  registered read data for the word addressed in the previous cycle.
- pmm_data  out  NUM_CH*DATA_W  per-channel committed pattern; channel c occupies [c*DATA_W +: DATA_W].
- pmm_control  out  NUM_CH*16  per-channel committed control; channel c occupies [c*16 +: 16].
- pmm_start  out  NUM_CH  one-cycle start pulse per channel.
- pmm_done  in  NUM_CH  per-channel completion pulse from the engines.
- irq  out  1  registered interrupt, level-high.

## Operation
Register map, by word index:
- 0..DW-1, DATA[i]: read/write staging buffer, bits [32i+31:32i]. Byte-enable granular.
- DW, CMD: write-only trigger; reads 0.
  - [15:0] = channel index; [31:16] = control.
  - A commit requires dwe == 4'hF. A partial-byte write to CMD is ignored entirely.
- DW+1, STATUS:
  - [NUM_CH-1:0] busy, read-only.
  - [31] cmd_err, sticky. Writing 1 to bit 31 with dwe[3]=1 clears it.
- DW+2, DONE: [NUM_CH-1:0] sticky done bits; write-1-to-clear, byte-enable qualified.
- DW+3, IRQ_EN: [NUM_CH-1:0] interrupt mask, read/write.
- Other words: writes ignored, reads return 0.

Commit rules, on a full-word CMD write, with ch = dwdata[15:0] and mode = dwdata[31:30]:
- ch >= NUM_CH: no channel change; set cmd_err.
- busy[ch] = 1, sampled before this edge: rejected; set cmd_err. This holds even if pmm_done[ch] is high in the same cycle.
- Otherwise:
  - pmm_data[ch] <= staging buffer; pmm_control[ch] <= dwdata[31:16].
  - If mode != 0: busy[ch] <= 1, pmm_start[ch] pulses, done[ch] <= 0.
  - If mode == 0: configuration-only load. No start pulse, busy unchanged.
- The staging buffer is unchanged by a commit, so it can be reused for other channels.

Done handling:
- pmm_done[c] with busy[c] = 1: busy[c] <= 0, done[c] <= 1.
- pmm_done[c] with busy[c] = 0: ignored.
- A DONE W1C in the same cycle as a hardware set of the same bit: the set wins.

Interrupt: irq <= |(done & irq_en), registered.

## Timing
- Reset: all outputs, staging buffer, busy, done, cmd_err and irq_en are 0. Reset is asynchronous and may be asserted mid-transaction; an in-flight start pulse is dropped.
- Write latency: register state updates at the edge where dwe != 0 is sampled. It is visible on drdata two edges after the read address is presented: one edge to update, one edge for the registered read.
- Read: drdata is registered from daddr every cycle, regardless of dwe, so latency is 1 cycle. A read concurrent with a write returns the pre-write value.
- Commit: pmm_data, pmm_control, busy and pmm_start all update at the same edge. pmm_start is high for exactly one cycle and then returns to 0.
- Back-to-back commits to different channels on consecutive cycles are all accepted.
- Done:
  - busy clears and done sets at the edge that samples pmm_done.
  - irq rises one edge after that.
  - A new commit to the same channel is accepted from the following cycle onward.

## Test plan
- Reset then read all map words: every read returns 0; irq = 0; pmm_start = 0.
- Stage the pattern and commit to channel 2:
  - Stimulus: DATA[0] = 0xDEADBEEF, DATA[1] = 0x01234567, then CMD = 0x4ABC0002.
  - Required: pmm_data[2] = 0x01234567DEADBEEF, pmm_control[2] = 0x4ABC, a single-cycle pmm_start[2], STATUS = 0x4.
- Commit CMD = 0x40000002 again while channel 2 is busy: STATUS[31] = 1 and pmm_data[2] is unchanged. Then commit CMD = 0x40000007: cmd_err stays set and no start pulse occurs. Write STATUS = 0x80000000: cmd_err clears.
- With IRQ_EN = 0x4, pulse pmm_done[2]: STATUS = 0, DONE = 0x4, and irq = 1 one cycle later. Write DONE = 0x4: irq = 0. A W1C concurrent with a fresh done leaves DONE = 0x4.
- Write DATA[0] = 0xFFFFFFFF with dwe = 4'b0011 over the old value 0xDEADBEEF: reads back 0xDEADFFFF. A CMD write with dwe = 4'b0111 produces no commit.
- Mode 0 commit, CMD = 0x00110001: pmm_control[1] = 0x0011, no pmm_start, busy[1] = 0. Assert rst_n low mid-sequence: all state returns to 0 asynchronously.
